// File: rtl/regfile_writeback_unit_pkg.sv
// Shared types for the writeback buffer: register id / data widths and the buffered entry.
package regfile_writeback_unit_pkg;

    localparam int REG_ID_W = 5;
    localparam int XLEN     = 32;

    typedef struct packed {
        logic [REG_ID_W-1:0] rd;
        logic [XLEN-1:0]     val;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_unit_wb_fwd_lookup.sv
// Combinational youngest-match search over the live window head..head+count-1 of the buffer.
module wb_fwd_lookup
    import regfile_writeback_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  wb_entry_t [DEPTH-1:0] i_entries,
    input  logic [PTR_W-1:0]      i_head,
    input  logic [PTR_W:0]        i_count,
    input  logic [REG_ID_W-1:0]   i_rs_id,
    output logic                  o_hit,
    output logic [XLEN-1:0]       o_val
);

    logic [PTR_W-1:0] w_idx;

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        o_hit = 1'b0;
        o_val = '0;
        w_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_head + PTR_W'(i);
            if ((i_rs_id != '0) && ((PTR_W+1)'(i) < i_count) &&
                (i_entries[w_idx].rd == i_rs_id)) begin
                o_hit = 1'b1;
                o_val = i_entries[w_idx].val;
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_unit.sv
// Merges ALU/LSU writebacks into an in-order FIFO that drives the register file write port,
// and forwards the youngest pending value for the two decode read ids.
module regfile_writeback_unit
    import regfile_writeback_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                flush_pipline,
    input  logic                wb0_valid,
    output logic                wb0_ready,
    input  logic [REG_ID_W-1:0] wb0_rd,
    input  logic [XLEN-1:0]     wb0_val,
    input  logic                wb1_valid,
    output logic                wb1_ready,
    input  logic [REG_ID_W-1:0] wb1_rd,
    input  logic [XLEN-1:0]     wb1_val,
    output logic                is_writing_rd,
    output logic [REG_ID_W-1:0] rd_reg_id,
    output logic [XLEN-1:0]     rd_val,
    input  logic [REG_ID_W-1:0] rs1_reg_id,
    output logic                rs1_fwd_hit,
    output logic [XLEN-1:0]     rs1_fwd_val,
    input  logic [REG_ID_W-1:0] rs2_reg_id,
    output logic                rs2_fwd_hit,
    output logic [XLEN-1:0]     rs2_fwd_val,
    output logic [PTR_W:0]      occupancy
);

    wb_entry_t [DEPTH-1:0] r_entries;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [PTR_W:0]        r_count;

    logic           w_active;
    logic [PTR_W:0] w_free;
    logic           w_wb0_zero;
    logic           w_wb1_zero;
    logic           w_wb0_push;
    logic           w_wb1_push;
    logic           w_pop;
    logic           w_not_empty;

    // Readies are gated by rst_n_in so they read 0 for the whole reset window.
    assign w_active    = rst_n_in && rdy_in && !flush_pipline;
    assign w_not_empty = (r_count != '0);
    assign w_free      = (PTR_W+1)'(DEPTH) - r_count;
    assign w_wb0_zero  = (wb0_rd == '0);
    assign w_wb1_zero  = (wb1_rd == '0);

    assign wb0_ready  = w_active && ((w_free != '0) || w_wb0_zero);
    assign w_wb0_push = wb0_valid && wb0_ready && !w_wb0_zero;

    // Free slots are counted at cycle start; a same-cycle pop is never credited.
    assign wb1_ready  = w_active && ((w_free >= (PTR_W+1)'(2)) ||
                                     ((w_free != '0) && !w_wb0_push) ||
                                     w_wb1_zero);
    assign w_wb1_push = wb1_valid && wb1_ready && !w_wb1_zero;

    assign w_pop = w_active && w_not_empty;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_entries <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
        end else if (rdy_in && flush_pipline) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_active) begin
            if (w_wb0_push) begin
                r_entries[r_tail] <= '{rd: wb0_rd, val: wb0_val};
            end
            // wb1 lands behind wb0 when both are accepted, keeping wb0 the older entry.
            if (w_wb1_push) begin
                r_entries[r_tail + PTR_W'(w_wb0_push)] <= '{rd: wb1_rd, val: wb1_val};
            end
            r_tail  <= r_tail + PTR_W'(w_wb0_push) + PTR_W'(w_wb1_push);
            r_head  <= r_head + PTR_W'(w_pop);
            r_count <= r_count + (PTR_W+1)'(w_wb0_push) + (PTR_W+1)'(w_wb1_push)
                       - (PTR_W+1)'(w_pop);
        end
    end

    assign is_writing_rd = w_pop;
    assign rd_reg_id     = w_not_empty ? r_entries[r_head].rd  : '0;
    assign rd_val        = w_not_empty ? r_entries[r_head].val : '0;
    assign occupancy     = r_count;

    wb_fwd_lookup #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd_rs1 (
        .i_entries (r_entries),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_rs_id   (rs1_reg_id),
        .o_hit     (rs1_fwd_hit),
        .o_val     (rs1_fwd_val)
    );

    wb_fwd_lookup #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd_rs2 (
        .i_entries (r_entries),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_rs_id   (rs2_reg_id),
        .o_hit     (rs2_fwd_hit),
        .o_val     (rs2_fwd_val)
    );

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Bench for regfile_writeback_unit: directed vector table, async-reset sequence, and random traffic vs a queue model.
module tb_regfile_writeback_unit;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_pipline;
    logic        wb0_valid;
    logic        wb0_ready;
    logic [4:0]  wb0_rd;
    logic [31:0] wb0_val;
    logic        wb1_valid;
    logic        wb1_ready;
    logic [4:0]  wb1_rd;
    logic [31:0] wb1_val;
    logic        is_writing_rd;
    logic [4:0]  rd_reg_id;
    logic [31:0] rd_val;
    logic [4:0]  rs1_reg_id;
    logic        rs1_fwd_hit;
    logic [31:0] rs1_fwd_val;
    logic [4:0]  rs2_reg_id;
    logic        rs2_fwd_hit;
    logic [31:0] rs2_fwd_val;
    logic [2:0]  occupancy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_in = ~clk_in;

    regfile_writeback_unit #(.DEPTH(4), .PTR_W(2)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .rdy_in        (rdy_in),
        .flush_pipline (flush_pipline),
        .wb0_valid     (wb0_valid),
        .wb0_ready     (wb0_ready),
        .wb0_rd        (wb0_rd),
        .wb0_val       (wb0_val),
        .wb1_valid     (wb1_valid),
        .wb1_ready     (wb1_ready),
        .wb1_rd        (wb1_rd),
        .wb1_val       (wb1_val),
        .is_writing_rd (is_writing_rd),
        .rd_reg_id     (rd_reg_id),
        .rd_val        (rd_val),
        .rs1_reg_id    (rs1_reg_id),
        .rs1_fwd_hit   (rs1_fwd_hit),
        .rs1_fwd_val   (rs1_fwd_val),
        .rs2_reg_id    (rs2_reg_id),
        .rs2_fwd_hit   (rs2_fwd_hit),
        .rs2_fwd_val   (rs2_fwd_val),
        .occupancy     (occupancy)
    );

    typedef struct {
        logic        rdy, flush, v0;
        logic [4:0]  rd0;
        logic [31:0] val0;
        logic        v1;
        logic [4:0]  rd1;
        logic [31:0] val1;
        logic [4:0]  rs1, rs2;
        logic        e_r0, e_r1, e_wr;
        logic [4:0]  e_rid;
        logic [31:0] e_rval;
        logic        e_h1;
        logic [31:0] e_v1;
        logic        e_h2;
        logic [31:0] e_v2;
        logic [2:0]  e_occ;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } ent_t;

    ent_t model_q[$];

    task automatic cmp(input string tag, input string field, input logic [31:0] got,
                       input logic [31:0] exp);
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s %s: got %0h expected %0h", tag, field, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic r0, input logic r1, input logic wr,
                             input logic [4:0] rid, input logic [31:0] rval,
                             input logic h1, input logic [31:0] v1,
                             input logic h2, input logic [31:0] v2, input logic [2:0] occ);
        vectors++;
        cmp(tag, "wb0_ready",     32'(wb0_ready),     32'(r0));
        cmp(tag, "wb1_ready",     32'(wb1_ready),     32'(r1));
        cmp(tag, "is_writing_rd", 32'(is_writing_rd), 32'(wr));
        cmp(tag, "rd_reg_id",     32'(rd_reg_id),     32'(rid));
        cmp(tag, "rd_val",        rd_val,             rval);
        cmp(tag, "rs1_fwd_hit",   32'(rs1_fwd_hit),   32'(h1));
        cmp(tag, "rs1_fwd_val",   rs1_fwd_val,        v1);
        cmp(tag, "rs2_fwd_hit",   32'(rs2_fwd_hit),   32'(h2));
        cmp(tag, "rs2_fwd_val",   rs2_fwd_val,        v2);
        cmp(tag, "occupancy",     32'(occupancy),     32'(occ));
    endtask

    task automatic drive(input logic rdy, input logic flush, input logic v0, input logic [4:0] rd0,
                         input logic [31:0] val0, input logic v1, input logic [4:0] rd1,
                         input logic [31:0] val1, input logic [4:0] rs1, input logic [4:0] rs2);
        rdy_in = rdy; flush_pipline = flush;
        wb0_valid = v0; wb0_rd = rd0; wb0_val = val0;
        wb1_valid = v1; wb1_rd = rd1; wb1_val = val1;
        rs1_reg_id = rs1; rs2_reg_id = rs2;
    endtask

    function automatic void fwd_model(input logic [4:0] rs, output logic h, output logic [31:0] v);
        h = 1'b0;
        v = '0;
        if (rs != 0) begin
            foreach (model_q[i]) begin
                if (model_q[i].rd == rs) begin
                    h = 1'b1;
                    v = model_q[i].val;
                end
            end
        end
    endfunction

    // One cycle of the reference model: check current outputs, then apply the edge's effect.
    task automatic model_cycle(input string tag);
        int cnt, fr;
        bit act, used0, used1;
        logic e_r0, e_r1, e_wr, h1, h2;
        logic [4:0] rid;
        logic [31:0] rval, v1, v2;
        cnt   = model_q.size();
        fr    = 4 - cnt;
        act   = rdy_in && !flush_pipline;
        e_r0  = act && (fr >= 1 || wb0_rd == 0);
        used0 = wb0_valid && e_r0 && wb0_rd != 0;
        e_r1  = act && (fr >= 2 || (fr >= 1 && !used0) || wb1_rd == 0);
        used1 = wb1_valid && e_r1 && wb1_rd != 0;
        e_wr  = act && cnt != 0;
        rid   = (cnt != 0) ? model_q[0].rd  : 5'd0;
        rval  = (cnt != 0) ? model_q[0].val : 32'd0;
        fwd_model(rs1_reg_id, h1, v1);
        fwd_model(rs2_reg_id, h2, v2);
        check_all(tag, e_r0, e_r1, e_wr, rid, rval, h1, v1, h2, v2, 3'(cnt));
        if (rdy_in && flush_pipline) begin
            model_q.delete();
        end else if (act) begin
            if (cnt != 0) void'(model_q.pop_front());
            if (used0) model_q.push_back('{rd: wb0_rd, val: wb0_val});
            if (used1) model_q.push_back('{rd: wb1_rd, val: wb1_val});
        end
    endtask

    vec_t tbl[21];

    initial begin
        //         rdy flush v0 rd0 val0     v1 rd1 val1      rs1 rs2  r0 r1 wr rid rval     h1 v1       h2 v2       occ
        tbl[0]  = '{1, 0, 1, 5,  'h11,   0, 0,  0,        5,  0,  1, 1, 0, 0,  0,      0, 0,      0, 0,      0};
        tbl[1]  = '{1, 0, 0, 0,  0,      0, 0,  0,        5,  0,  1, 1, 1, 5,  'h11,   1, 'h11,   0, 0,      1};
        tbl[2]  = '{1, 0, 1, 3,  'hA,    1, 3,  'hB,      3,  0,  1, 1, 0, 0,  0,      0, 0,      0, 0,      0};
        tbl[3]  = '{1, 0, 0, 0,  0,      0, 0,  0,        3,  5,  1, 1, 1, 3,  'hA,    1, 'hB,    0, 0,      2};
        tbl[4]  = '{1, 0, 0, 0,  0,      0, 0,  0,        3,  0,  1, 1, 1, 3,  'hB,    1, 'hB,    0, 0,      1};
        tbl[5]  = '{1, 0, 0, 0,  0,      0, 0,  0,        3,  0,  1, 1, 0, 0,  0,      0, 0,      0, 0,      0};
        tbl[6]  = '{1, 0, 1, 1,  'h100,  1, 2,  'h200,    2,  1,  1, 1, 0, 0,  0,      0, 0,      0, 0,      0};
        tbl[7]  = '{1, 0, 1, 4,  'h400,  1, 6,  'h600,    2,  1,  1, 1, 1, 1,  'h100,  1, 'h200,  1, 'h100,  2};
        tbl[8]  = '{1, 0, 1, 7,  'h700,  1, 8,  'h800,    2,  6,  1, 0, 1, 2,  'h200,  1, 'h200,  1, 'h600,  3};
        tbl[9]  = '{0, 0, 1, 9,  'h900,  1, 10, 'hA00,    6,  7,  0, 0, 0, 4,  'h400,  1, 'h600,  1, 'h700,  3};
        tbl[10] = '{0, 0, 0, 0,  0,      0, 0,  0,        4,  8,  0, 0, 0, 4,  'h400,  1, 'h400,  0, 0,      3};
        tbl[11] = '{1, 0, 1, 9,  'h900,  1, 10, 'hA00,    7,  10, 1, 0, 1, 4,  'h400,  1, 'h700,  0, 0,      3};
        tbl[12] = '{1, 0, 1, 11, 'hB00,  1, 0,  'hFFFF,   9,  0,  1, 1, 1, 6,  'h600,  1, 'h900,  0, 0,      3};
        tbl[13] = '{1, 0, 0, 0,  0,      0, 0,  0,        0,  11, 1, 1, 1, 7,  'h700,  0, 0,      1, 'hB00,  3};
        tbl[14] = '{1, 0, 1, 12, 'hC00,  1, 13, 'hD00,    11, 0,  1, 1, 1, 9,  'h900,  1, 'hB00,  0, 0,      2};
        tbl[15] = '{1, 1, 1, 14, 'hE00,  0, 0,  0,        13, 12, 0, 0, 0, 11, 'hB00,  1, 'hD00,  1, 'hC00,  3};
        tbl[16] = '{1, 0, 0, 0,  0,      0, 0,  0,        13, 11, 1, 1, 0, 0,  0,      0, 0,      0, 0,      0};
        tbl[17] = '{0, 1, 1, 15, 'hF,    1, 16, 'h10,     0,  0,  0, 0, 0, 0,  0,      0, 0,      0, 0,      0};
        tbl[18] = '{1, 0, 1, 0,  'h55,   1, 17, 'h1700,   0,  0,  1, 1, 0, 0,  0,      0, 0,      0, 0,      0};
        tbl[19] = '{1, 0, 0, 0,  0,      0, 0,  0,        0,  17, 1, 1, 1, 17, 'h1700, 0, 0,      1, 'h1700, 1};
        tbl[20] = '{1, 0, 0, 0,  0,      0, 0,  0,        0,  0,  1, 1, 0, 0,  0,      0, 0,      0, 0,      0};

        rst_n_in = 1'b0;
        drive(1, 0, 1, 5, 32'h11, 1, 6, 32'h22, 5, 6);
        #3;
        check_all("in_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk_in);
            drive(tbl[i].rdy, tbl[i].flush, tbl[i].v0, tbl[i].rd0, tbl[i].val0,
                  tbl[i].v1, tbl[i].rd1, tbl[i].val1, tbl[i].rs1, tbl[i].rs2);
            #1;
            check_all($sformatf("vec%0d", i), tbl[i].e_r0, tbl[i].e_r1, tbl[i].e_wr, tbl[i].e_rid,
                      tbl[i].e_rval, tbl[i].e_h1, tbl[i].e_v1, tbl[i].e_h2, tbl[i].e_v2,
                      tbl[i].e_occ);
        end

        // Async reset landing between edges in the middle of a burst.
        @(negedge clk_in);
        drive(1, 0, 1, 20, 32'h1, 1, 21, 32'h2, 21, 20);
        @(negedge clk_in);
        drive(1, 0, 1, 22, 32'h3, 0, 0, 0, 21, 22);
        @(posedge clk_in);
        #2;
        check_all("pre_rst", 1, 1, 1, 21, 32'h2, 1, 32'h2, 1, 32'h3, 2);
        rst_n_in = 1'b0;
        #1;
        check_all("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_in);
        #3;
        rst_n_in = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 21, 22);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            #1;
            check_all($sformatf("post_rst%0d", i), 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        model_q.delete();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk_in);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            model_cycle($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
